// File: rtl/vcpu32_regfile_pkg.sv
// Shared definitions for the bypassing register file.
// Holds the clear/ready state encoding and the supported parameter limits.
package vcpu32_regfile_pkg;

  // Largest supported register count and read-port count.
  localparam int unsigned MAX_SIZE = 64;
  localparam int unsigned MAX_RD   = 4;

  // CLEAR: storage is being zeroed one entry per cycle; READY: normal use.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/bypass_read_port.sv
// One combinational read port of the register file.
// Ports:
//   addr              - read address
//   busy              - storage is being cleared; forces data to zero
//   regs              - current storage contents
//   wr_en_a/b         - write enables already qualified by the top (ready, in range, not reg 0)
//   wr_addr_a/b       - write addresses
//   wr_data_a/b       - write data, forwarded when BYPASS is set
//   data              - read result
module bypass_read_port
  import vcpu32_regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 8,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned AW       = $clog2(SIZE)
) (
  input  logic [AW-1:0]    addr,
  input  logic             busy,
  input  logic [WIDTH-1:0] regs [SIZE],
  input  logic             wr_en_a,
  input  logic [AW-1:0]    wr_addr_a,
  input  logic [WIDTH-1:0] wr_data_a,
  input  logic             wr_en_b,
  input  logic [AW-1:0]    wr_addr_b,
  input  logic [WIDTH-1:0] wr_data_b,
  output logic [WIDTH-1:0] data
);

  logic in_range;
  logic is_zero;
  logic hit_a;
  logic hit_b;

  // Addresses past SIZE exist only when SIZE is not a power of two.
  assign in_range = 32'(addr) < SIZE;
  assign is_zero  = (ZERO_REG != 0) && (addr == '0);

  assign hit_a = (BYPASS != 0) && wr_en_a && (wr_addr_a == addr);
  assign hit_b = (BYPASS != 0) && wr_en_b && (wr_addr_b == addr);

  // Port B wins over port A on forwarding, matching the storage priority.
  always_comb begin
    data = '0;
    if (!busy && in_range && !is_zero) begin
      if (hit_b) begin
        data = wr_data_b;
      end else if (hit_a) begin
        data = wr_data_a;
      end else begin
        data = regs[addr];
      end
    end
  end

endmodule

// File: rtl/bypass_reg_file.sv
// Two-write, multi-read register file with optional same-cycle forwarding,
// optional hardwired-zero register 0, and a sequential clear after reset.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   wrEnA/wrEnB       - write enables (B has priority on address collision)
//   wrAddrA/wrAddrB   - write addresses
//   wrDataA/wrDataB   - write data
//   rdAddr            - packed read addresses, port 0 in the top slice
//   rdData            - packed combinational read data, same slice order
//   busy              - high while the storage is being cleared
module bypass_reg_file
  import vcpu32_regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned SIZE     = 8,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned BYPASS   = 1,
  parameter  int unsigned ZERO_REG = 0,
  localparam int unsigned AW       = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrEnA,
  input  logic                    wrEnB,
  input  logic [AW-1:0]           wrAddrA,
  input  logic [AW-1:0]           wrAddrB,
  input  logic [WIDTH-1:0]        wrDataA,
  input  logic [WIDTH-1:0]        wrDataB,
  input  logic [NUM_RD*AW-1:0]    rdAddr,
  output logic [NUM_RD*WIDTH-1:0] rdData,
  output logic                    busy
);

  logic [WIDTH-1:0] regs [SIZE];

  rf_state_e        state_q;
  rf_state_e        state_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;
  logic             busy_q;
  logic             clr_en;
  logic             wr_a;
  logic             wr_b;

  // An address accepts writes when it exists and is not the hardwired zero.
  function automatic logic writable(input logic [AW-1:0] a);
    return (32'(a) < SIZE) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes land only in READY and never on a reset edge.
  assign wr_a = wrEnA && !busy_q && !rst && writable(wrAddrA);
  assign wr_b = wrEnB && !busy_q && !rst && writable(wrAddrB);

  assign busy = busy_q;

  // State, clear counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  // Next-state logic: walk the counter across every entry, then go READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = !rst;
        if (cnt_q == AW'(SIZE - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage; the B assignment comes last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs[cnt_q] <= '0;
    end else begin
      if (wr_a) begin
        regs[wrAddrA] <= wrDataA;
      end
      if (wr_b) begin
        regs[wrAddrB] <= wrDataB;
      end
    end
  end

  // Read ports; port 0 maps to the most significant slices.
  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    bypass_read_port #(
      .WIDTH    (WIDTH),
      .SIZE     (SIZE),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_port (
      .addr      (rdAddr[(int'(NUM_RD) - 1 - i) * int'(AW) +: AW]),
      .busy      (busy_q),
      .regs      (regs),
      .wr_en_a   (wr_a),
      .wr_addr_a (wrAddrA),
      .wr_data_a (wrDataA),
      .wr_en_b   (wr_b),
      .wr_addr_b (wrAddrB),
      .wr_data_b (wrDataB),
      .data      (rdData[(int'(NUM_RD) - 1 - i) * int'(WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_bypass_reg_file.sv
// Scoreboard bench: three configurations share one stimulus stream.
//   c0: SIZE=8 BYPASS=1 ZERO_REG=0
//   c1: SIZE=6 BYPASS=0 ZERO_REG=1
//   c2: SIZE=8 BYPASS=1 ZERO_REG=1
module tb_bypass_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEnA, wrEnB;
  logic [2:0]  wrAddrA, wrAddrB;
  logic [31:0] wrDataA, wrDataB;
  logic [5:0]  rdAddr;
  logic [63:0] rd_c0, rd_c1, rd_c2;
  logic        busy_c0, busy_c1, busy_c2;

  always #5 clk = ~clk;

  bypass_reg_file #(.WIDTH(32), .SIZE(8), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) u_c0 (
    .clk(clk), .rst(rst), .wrEnA(wrEnA), .wrEnB(wrEnB), .wrAddrA(wrAddrA), .wrAddrB(wrAddrB),
    .wrDataA(wrDataA), .wrDataB(wrDataB), .rdAddr(rdAddr), .rdData(rd_c0), .busy(busy_c0));
  bypass_reg_file #(.WIDTH(32), .SIZE(6), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u_c1 (
    .clk(clk), .rst(rst), .wrEnA(wrEnA), .wrEnB(wrEnB), .wrAddrA(wrAddrA), .wrAddrB(wrAddrB),
    .wrDataA(wrDataA), .wrDataB(wrDataB), .rdAddr(rdAddr), .rdData(rd_c1), .busy(busy_c1));
  bypass_reg_file #(.WIDTH(32), .SIZE(8), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_c2 (
    .clk(clk), .rst(rst), .wrEnA(wrEnA), .wrEnB(wrEnB), .wrAddrA(wrAddrA), .wrAddrB(wrAddrB),
    .wrDataA(wrDataA), .wrDataB(wrDataB), .rdAddr(rdAddr), .rdData(rd_c2), .busy(busy_c2));

  // Reference model: contents per config plus remaining busy cycles.
  int          cfg_size [3] = '{8, 6, 8};
  bit          cfg_byp  [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_zr   [3] = '{1'b0, 1'b1, 1'b1};
  logic [31:0] mem      [3][8];
  int          busy_left[3] = '{0, 0, 0};

  typedef struct packed {
    logic [31:0]      tag;
    logic [2:0]       busy;
    logic [5:0][31:0] rd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_tag = 0;

  function automatic bit writable(int c, logic [2:0] a);
    return (int'(a) < cfg_size[c]) && !(cfg_zr[c] && a == 3'd0);
  endfunction

  function automatic logic [31:0] model_rd(int c, logic [2:0] a);
    if (busy_left[c] > 0) return 32'h0;
    if (!writable(c, a)) return 32'h0;
    if (cfg_byp[c] && !rst) begin
      if (wrEnB && wrAddrB == a) return wrDataB;
      if (wrEnA && wrAddrA == a) return wrDataA;
    end
    return mem[c][a];
  endfunction

  // Apply the effect of one rising edge to the model.
  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        busy_left[c] = cfg_size[c];
      end else if (busy_left[c] > 0) begin
        busy_left[c] = busy_left[c] - 1;
        if (busy_left[c] == 0)
          for (int i = 0; i < 8; i++) mem[c][i] = 32'h0;
      end else begin
        if (wrEnA && writable(c, wrAddrA)) mem[c][wrAddrA] = wrDataA;
        if (wrEnB && writable(c, wrAddrB)) mem[c][wrAddrB] = wrDataB;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, advance the edge.
  task automatic step(input bit chk, input bit r,
                      input bit ea, input logic [2:0] aa, input logic [31:0] da,
                      input bit eb, input logic [2:0] ab, input logic [31:0] db,
                      input logic [2:0] r0, input logic [2:0] r1);
    exp_t e;
    rst = r; wrEnA = ea; wrAddrA = aa; wrDataA = da;
    wrEnB = eb; wrAddrB = ab; wrDataB = db; rdAddr = {r0, r1};
    if (chk) begin
      e.tag = 32'(cur_tag);
      for (int c = 0; c < 3; c++) begin
        e.busy[c]     = busy_left[c] > 0;
        e.rd[c*2]     = model_rd(c, r0);
        e.rd[c*2 + 1] = model_rd(c, r1);
      end
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] r0, input logic [2:0] r1);
    for (int k = 0; k < n; k++) step(1, 0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, r0, r1);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act_rd;
    logic        act_busy;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int c = 0; c < 3; c++) begin
        act_rd   = (c == 0) ? rd_c0 : (c == 1) ? rd_c1 : rd_c2;
        act_busy = (c == 0) ? busy_c0 : (c == 1) ? busy_c1 : busy_c2;
        n_cmp++;
        if (act_busy !== e.busy[c]) begin
          n_bad++;
          $display("FAIL busy tag=%0d cfg=%0d got=%b want=%b t=%0t", e.tag, c, act_busy, e.busy[c], $time);
        end
        for (int p = 0; p < 2; p++) begin
          n_cmp++;
          if ((p == 0 ? act_rd[63:32] : act_rd[31:0]) !== e.rd[c*2 + p]) begin
            n_bad++;
            $display("FAIL rdData tag=%0d cfg=%0d port=%0d got=%h want=%h t=%0t",
                     e.tag, c, p, (p == 0 ? act_rd[63:32] : act_rd[31:0]), e.rd[c*2 + p], $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state and a full clear sequence.
    cur_tag = 0;
    step(0, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd0, 3'd1);
    step(1, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd0, 3'd1);
    idle(10, 3'd2, 3'd7);

    // Preloaded value is wiped by a one-cycle reset pulse.
    cur_tag = 1;
    step(1, 0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0, 3'd3, 3'd4);
    idle(1, 3'd3, 3'd3);
    step(1, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd3, 3'd3);
    idle(10, 3'd3, 3'd3);

    // Reset reasserted partway through clearing restarts the sequence.
    cur_tag = 2;
    step(1, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd1, 3'd2);
    idle(4, 3'd1, 3'd2);
    step(1, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd1, 3'd2);
    idle(10, 3'd1, 3'd2);

    // Same-address collision: port B wins.
    cur_tag = 3;
    step(1, 0, 1, 3'd5, 32'h11111111, 1, 3'd5, 32'h22222222, 3'd5, 3'd5);
    idle(2, 3'd5, 3'd5);

    // Same-cycle forwarding on port 0.
    cur_tag = 4;
    step(1, 0, 1, 3'd2, 32'hCAFEF00D, 0, 3'd0, 32'h0, 3'd2, 3'd5);
    idle(1, 3'd2, 3'd2);

    // Write to register 0.
    cur_tag = 5;
    step(1, 0, 1, 3'd0, 32'hFFFFFFFF, 0, 3'd0, 32'h0, 3'd0, 3'd0);
    idle(1, 3'd0, 3'd0);

    // Address 7: valid with SIZE=8, out of range with SIZE=6.
    cur_tag = 6;
    step(1, 0, 1, 3'd7, 32'hABCD1234, 1, 3'd6, 32'h66666666, 3'd7, 3'd6);
    idle(1, 3'd7, 3'd6);

    // Writes during clearing are dropped.
    cur_tag = 7;
    step(1, 1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 3'd1, 3'd4);
    step(1, 0, 1, 3'd1, 32'h55555555, 1, 3'd4, 32'h44444444, 3'd1, 3'd4);
    idle(10, 3'd1, 3'd4);

    // Random traffic with occasional resets.
    cur_tag = 8;
    for (int k = 0; k < 600; k++) begin
      step(1, ($urandom_range(0, 79) == 0),
           1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
           1'($urandom_range(0, 1)), 3'($urandom), $urandom,
           3'($urandom), 3'($urandom));
    end

    // Drain and confirm every queued expectation was consumed.
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: entries left got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bypass_reg_file.md
BYPASS_REG_FILE -- requirements
Module: bypass_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter SIZE, default 8, number of registers (2..64); AW = $clog2(SIZE).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_REG, default 0, 1 = register 0 reads zero and ignores writes.
REQ-006 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports wrEnA/wrEnB, input, 1 each, write enables for write ports A and B.
REQ-009 SHALL have ports wrAddrA/wrAddrB, input, AW each, write addresses.
REQ-010 SHALL have ports wrDataA/wrDataB, input, WIDTH each, write data.
REQ-011 SHALL have port rdAddr, input, NUM_RD*AW, packed read addresses, port 0 in the most significant slice.
REQ-012 SHALL have port rdData, output, NUM_RD*WIDTH, packed read data, same slice order as rdAddr.
REQ-013 SHALL have port busy, output, 1, high while reset clearing is in progress.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 SHALL hold CLEAR with clear counter = 0 in every cycle where rst is sampled high.
REQ-016 SHALL, in CLEAR with rst low, write 0 to reg[counter] and increment the counter each cycle, then enter READY after the cycle that clears SIZE-1. busy is therefore high for exactly SIZE cycles after rst falls.
REQ-017 SHALL restart clearing from counter 0 if rst is asserted mid-clear.
REQ-018 SHALL drop all wrEnA/wrEnB writes while busy is high.
REQ-019 SHALL drive every rdData slice to 0 while busy is high.
REQ-020 SHALL, in READY, write wrDataA/wrDataB on the rising edge when the matching enable is high.
REQ-021 SHALL, when both write ports target the same address in one cycle, store wrDataB only (port B has priority).
REQ-022 SHALL provide combinational reads: rdData[i] = reg[rdAddr[i]] with zero cycles of latency.
REQ-023 SHALL, with BYPASS=1, return the data of an enabled write whose address matches rdAddr[i] in the same cycle (B over A). With BYPASS=0, the newly written value appears on the cycle after the write.
REQ-024 SHALL, with ZERO_REG=1, read address 0 as 0 on all ports, discard writes to address 0, and not forward a bypass for address 0.
REQ-025 SHALL ignore writes to addresses >= SIZE and return 0 for reads of addresses >= SIZE (non-power-of-two SIZE).
REQ-026 SHALL let all read ports read the same address simultaneously without interference.

Reset
REQ-027 SHALL treat rst as synchronous: there is no asynchronous path from rst to any state element.
REQ-028 SHALL drive busy to 1 from the first clk edge with rst high, and rdData to 0 from that edge.
REQ-029 SHALL leave every register at 0 when busy falls.

Structure
REQ-030 SHALL place the FSM state encoding (CLEAR, READY) and the limits MAX_SIZE=64 and MAX_RD=4 in the shared package vcpu32_regfile_pkg.
REQ-031 SHALL implement the per-port address decode, bypass and zero logic as sub-module bypass_read_port, instantiated NUM_RD times by generate.
REQ-032 SHALL keep the storage array and the FSM in bypass_reg_file.

Verification
REQ-033 SHALL cover reset clearing: preload reg3=0xDEADBEEF, pulse rst for 1 cycle -> busy high for 8 cycles, rdData=0 during busy, reg3 reads 0x00000000 after busy falls.
REQ-034 SHALL cover mid-clear reset: reassert rst at clear cycle 4 -> busy stays high 8 more cycles after rst falls.
REQ-035 SHALL cover write collision: wrEnA=wrEnB=1, both to addr 5, A=0x11111111, B=0x22222222 -> reg5 reads 0x22222222.
REQ-036 SHALL cover bypass: BYPASS=1, write addr 2 = 0xCAFEF00D while rdAddr port0=2 -> rdData port0 = 0xCAFEF00D in the same cycle. BYPASS=0 -> old value that cycle, 0xCAFEF00D the next cycle.
REQ-037 SHALL cover ZERO_REG: ZERO_REG=1, write addr 0 = 0xFFFFFFFF -> all ports reading addr 0 return 0, and no bypass occurs.
REQ-038 SHALL cover writes while busy and out-of-range addresses: write during CLEAR is dropped. With SIZE=6, a write to addr 7 is ignored and a read of addr 7 returns 0.
